// File: rtl/riscv_pkg.sv
// riscv_pkg: M-extension encodings and sequencer state codes shared by the core
package riscv_pkg;
    localparam logic [6:0] OP_RTYPE    = 7'b0110011;
    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;
    localparam logic [2:0] MUL_F3      = 3'b000;
    localparam logic [2:0] MULH_F3     = 3'b001;
    localparam logic [2:0] MULHSU_F3   = 3'b010;
    localparam logic [2:0] MULHU_F3    = 3'b011;
    localparam logic [2:0] DIV_F3      = 3'b100;
    localparam logic [2:0] DIVU_F3     = 3'b101;
    localparam logic [2:0] REM_F3      = 3'b110;
    localparam logic [2:0] REMU_F3     = 3'b111;
    localparam logic [1:0] IDLE        = 2'b00;
    localparam logic [1:0] BUSY        = 2'b01;
    localparam logic [1:0] DONE        = 2'b10;
endpackage

// File: rtl/mdu_sequencer_if.sv
// mdu_sequencer_if: Execute-stage request/stall/result bundle between pipeline and MDU
interface mdu_sequencer_if #(
    parameter int XLEN = 32
);
    logic            StartE;
    logic [2:0]      funct3E;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic            FlushE;
    logic            StallMDU;
    logic            DoneMDU;
    logic [XLEN-1:0] ResultMDU;
    modport master (
        output StartE, funct3E, SrcAE, SrcBE, FlushE,
        input  StallMDU, DoneMDU, ResultMDU
    );
    modport slave (
        input  StartE, funct3E, SrcAE, SrcBE, FlushE,
        output StallMDU, DoneMDU, ResultMDU
    );
endinterface

// File: rtl/mdu_datapath.sv
// mdu_datapath: operand registers, shift-add multiply / restoring divide iteration and result fix-up
module mdu_datapath
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            quick,
    input  logic            step,
    input  logic            finish,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);
    logic [2:0]        op;
    logic              neg;
    logic [XLEN-1:0]   mb;
    logic [2*XLEN-1:0] acc;
    logic [XLEN:0]     rem;
    logic              sa, sb, is_rem, dz, neg_n;
    logic [XLEN-1:0]   mag_a, mag_b, fast_res, addend, quo_n, q_fix, r_fix, fin_res;
    logic [XLEN:0]     mul_sum, rem_n;
    logic [XLEN+1:0]   shifted, diff;
    logic [2*XLEN-1:0] mul_n, acc_n, prod_fix;
    // Operand sign/magnitude at start, the next iteration value and the signed result candidates
    always_comb begin
        sa       = a[XLEN-1] && (funct3 == MULH_F3 || funct3 == MULHSU_F3 || funct3 == DIV_F3 || funct3 == REM_F3);
        sb       = b[XLEN-1] && (funct3 == MULH_F3 || funct3 == DIV_F3 || funct3 == REM_F3);
        mag_a    = sa ? -a : a;
        mag_b    = sb ? -b : b;
        is_rem   = funct3[2] && funct3[1];
        neg_n    = is_rem ? sa : sa ^ sb;
        dz       = b == '0;
        fast_res = is_rem ? (dz ? a : '0) : (dz ? '1 : {1'b1, {(XLEN-1){1'b0}}});
        addend   = acc[0] ? mb : '0;
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, addend};
        mul_n    = {mul_sum, acc[XLEN-1:1]};
        shifted  = {rem, acc[XLEN-1]};
        diff     = shifted - {2'b00, mb};
        rem_n    = diff[XLEN+1] ? shifted[XLEN:0] : diff[XLEN:0];
        quo_n    = {acc[XLEN-2:0], ~diff[XLEN+1]};
        acc_n    = op[2] ? {acc[2*XLEN-1:XLEN], quo_n} : mul_n;
        prod_fix = neg ? -mul_n : mul_n;
        q_fix    = neg ? -quo_n : quo_n;
        r_fix    = neg ? -rem_n[XLEN-1:0] : rem_n[XLEN-1:0];
        fin_res  = op[2] ? (op[1] ? r_fix : q_fix) : (op[1:0] == 2'b00 ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);
    end
    // Latch op and magnitudes at start, iterate while busy, register the final or fast-path result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op     <= '0;
            neg    <= 1'b0;
            mb     <= '0;
            acc    <= '0;
            rem    <= '0;
            result <= '0;
        end else begin
            if (load) begin
                op  <= funct3;
                neg <= neg_n;
                mb  <= mag_b;
                acc <= {{XLEN{1'b0}}, mag_a};
                rem <= '0;
            end else if (step) begin
                acc <= acc_n;
                rem <= rem_n;
            end
            if (quick)
                result <= fast_res;
            else if (finish)
                result <= fin_res;
        end
    end
endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: RV32M multi-cycle multiply/divide FSM with pipeline stall control
module mdu_sequencer
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input logic            clk,
    input logic            reset,
    mdu_sequencer_if.slave bus
);
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             start, special, last, step, finish;
    logic [XLEN-1:0]  result;
    // Start/iteration strobes; divide-by-zero and signed overflow bypass the iterations
    always_comb begin
        start   = state == IDLE && bus.StartE && !bus.FlushE;
        special = bus.funct3E[2] && (bus.SrcBE == '0 ||
                  (!bus.funct3E[0] && bus.SrcAE == {1'b1, {(XLEN-1){1'b0}}} && bus.SrcBE == '1));
        last    = cnt == CNT_W'(XLEN-1);
        step    = state == BUSY && !bus.FlushE;
        finish  = step && last;
        bus.StallMDU  = reset && (start || state == BUSY);
        bus.DoneMDU   = state == DONE;
        bus.ResultMDU = result;
    end
    // State and iteration counter; DONE always returns to IDLE so StartE there is ignored
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state == IDLE ? (start ? (special ? DONE : BUSY) : IDLE) :
                     state == BUSY ? (bus.FlushE ? IDLE : (last ? DONE : BUSY)) : IDLE;
            cnt   <= (step && !last) ? cnt + 1'b1 : '0;
        end
    end
    mdu_datapath #(.XLEN(XLEN)) u_dp (
        .clk    (clk),
        .reset  (reset),
        .load   (start),
        .quick  (start && special),
        .step   (step),
        .finish (finish),
        .funct3 (bus.funct3E),
        .a      (bus.SrcAE),
        .b      (bus.SrcBE),
        .result (result)
    );
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed and randomized RV32M checks against a 64-bit arithmetic model
module tb_mdu_sequencer;
    import riscv_pkg::*;
    logic clk = 1'b0;
    logic reset;
    int compared = 0;
    int mismatched = 0;
    always #5 clk = ~clk;
    mdu_sequencer_if #(.XLEN(32)) bus();
    mdu_sequencer #(.XLEN(32), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    // Architectural result from plain 64-bit arithmetic
    function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        r = '0;
        case (f3)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input string name);
        logic [31:0] exp, res;
        logic fast;
        int lat, stalls, done_at;
        logic stall_at_done;
        exp = ref_mdu(f3, a, b);
        fast = f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
        lat = fast ? 1 : 33;
        @(negedge clk);
        bus.StartE = 1'b1; bus.funct3E = f3; bus.SrcAE = a; bus.SrcBE = b;
        #1;
        stalls = bus.StallMDU ? 1 : 0;
        done_at = -1;
        res = '0;
        stall_at_done = 1'b1;
        for (int c = 1; c <= 40 && done_at < 0; c++) begin
            @(posedge clk); #1;
            if (bus.DoneMDU) begin
                done_at = c; res = bus.ResultMDU; stall_at_done = bus.StallMDU;
            end else if (bus.StallMDU) stalls++;
        end
        bus.StartE = 1'b0;
        compared++;
        if (done_at !== lat) begin mismatched++; $display("FAIL %s done_cycle: got %0d want %0d", name, done_at, lat); end
        compared++;
        if (stalls !== lat) begin mismatched++; $display("FAIL %s stall_cycles: got %0d want %0d", name, stalls, lat); end
        compared++;
        if (res !== exp) begin mismatched++; $display("FAIL %s result: got %h want %h", name, res, exp); end
        compared++;
        if (stall_at_done !== 1'b0) begin mismatched++; $display("FAIL %s stall_in_done: got %b want 0", name, stall_at_done); end
        @(posedge clk); #1;
        compared++;
        if (bus.DoneMDU !== 1'b0) begin mismatched++; $display("FAIL %s done_one_cycle: got %b want 0", name, bus.DoneMDU); end
    endtask
    task automatic test_reset();
        reset = 1'b0;
        bus.StartE = 1'b0; bus.FlushE = 1'b0; bus.funct3E = '0; bus.SrcAE = '0; bus.SrcBE = '0;
        repeat (3) @(posedge clk);
        #1;
        bus.StartE = 1'b1;
        #1;
        compared++;
        if (bus.StallMDU !== 1'b0) begin mismatched++; $display("FAIL reset_stall: got %b want 0", bus.StallMDU); end
        compared++;
        if (bus.DoneMDU !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b want 0", bus.DoneMDU); end
        compared++;
        if (bus.ResultMDU !== 32'h0) begin mismatched++; $display("FAIL reset_result: got %h want 0", bus.ResultMDU); end
        compared++;
        if (dut.state !== IDLE) begin mismatched++; $display("FAIL reset_state: got %b want %b", dut.state, IDLE); end
        bus.StartE = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask
    task automatic test_directed();
        run_op(MUL_F3, 32'd7, 32'hFFFFFFFD, "mul_neg");
        run_op(MULHU_F3, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhu_max");
        run_op(MULH_F3, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulh_m1");
        run_op(MULHSU_F3, 32'hFFFFFFFF, 32'd2, "mulhsu");
        run_op(DIV_F3, 32'hFFFFFFF9, 32'd2, "div_neg");
        run_op(REM_F3, 32'hFFFFFFF9, 32'd2, "rem_neg");
        run_op(DIVU_F3, 32'd100, 32'd7, "divu");
        run_op(REMU_F3, 32'd100, 32'd7, "remu");
        run_op(DIVU_F3, 32'd5, 32'd0, "divu_by0");
        run_op(REMU_F3, 32'd5, 32'd0, "remu_by0");
        run_op(DIV_F3, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        run_op(REM_F3, 32'h80000000, 32'hFFFFFFFF, "rem_ovf");
        run_op(DIV_F3, 32'h12345678, 32'd0, "div_by0");
        run_op(DIVU_F3, 32'h80000000, 32'hFFFFFFFF, "divu_no_ovf");
    endtask
    task automatic test_random();
        logic [2:0] f3;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 9) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            if ($urandom_range(0, 4) == 0) b = 32'($urandom_range(1, 300));
            run_op(f3, a, b, $sformatf("rand%0d_f%0d", i, f3));
        end
    endtask
    task automatic test_flush();
        int dones;
        @(negedge clk);
        bus.StartE = 1'b1; bus.funct3E = DIV_F3; bus.SrcAE = 32'd100; bus.SrcBE = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        bus.StartE = 1'b0; bus.FlushE = 1'b1;
        #1;
        compared++;
        if (bus.StallMDU !== 1'b1) begin mismatched++; $display("FAIL flush_c10_stall: got %b want 1", bus.StallMDU); end
        @(posedge clk); #1;
        compared++;
        if (dut.state !== IDLE) begin mismatched++; $display("FAIL flush_c11_state: got %b want %b", dut.state, IDLE); end
        compared++;
        if (bus.StallMDU !== 1'b0) begin mismatched++; $display("FAIL flush_c11_stall: got %b want 0", bus.StallMDU); end
        bus.FlushE = 1'b0;
        dones = 0;
        repeat (40) begin @(posedge clk); #1; if (bus.DoneMDU) dones++; end
        compared++;
        if (dones !== 0) begin mismatched++; $display("FAIL flush_no_done: got %0d want 0", dones); end
        @(negedge clk);
        bus.StartE = 1'b1; bus.FlushE = 1'b1;
        #1;
        compared++;
        if (bus.StallMDU !== 1'b0) begin mismatched++; $display("FAIL flush_idle_stall: got %b want 0", bus.StallMDU); end
        @(posedge clk); #1;
        compared++;
        if (dut.state !== IDLE) begin mismatched++; $display("FAIL flush_idle_state: got %b want %b", dut.state, IDLE); end
        bus.StartE = 1'b0; bus.FlushE = 1'b0;
    endtask
    task automatic test_reset_mid();
        int dones;
        @(negedge clk);
        bus.StartE = 1'b1; bus.funct3E = MUL_F3; bus.SrcAE = 32'd123; bus.SrcBE = 32'd456;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        compared++;
        if (bus.StallMDU !== 1'b0) begin mismatched++; $display("FAIL rstmid_stall: got %b want 0", bus.StallMDU); end
        compared++;
        if (bus.DoneMDU !== 1'b0) begin mismatched++; $display("FAIL rstmid_done: got %b want 0", bus.DoneMDU); end
        compared++;
        if (bus.ResultMDU !== 32'h0) begin mismatched++; $display("FAIL rstmid_result: got %h want 0", bus.ResultMDU); end
        bus.StartE = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        dones = 0;
        repeat (40) begin @(posedge clk); #1; if (bus.DoneMDU) dones++; end
        compared++;
        if (dones !== 0) begin mismatched++; $display("FAIL rstmid_no_done: got %0d want 0", dones); end
    endtask
    task automatic test_back_to_back();
        int first, second, ndone;
        logic [31:0] r1, r2;
        logic [1:0] state34;
        logic stall34;
        first = -1; second = -1; ndone = 0; r1 = '0; r2 = '0; state34 = 2'b11; stall34 = 1'b0;
        @(negedge clk);
        bus.StartE = 1'b1; bus.funct3E = MUL_F3; bus.SrcAE = 32'd7; bus.SrcBE = 32'hFFFFFFFD;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #1;
            if (c == 34) begin state34 = dut.state; stall34 = bus.StallMDU; end
            if (bus.DoneMDU) begin
                ndone++;
                if (first < 0) begin
                    first = c; r1 = bus.ResultMDU;
                    bus.funct3E = DIVU_F3; bus.SrcAE = 32'd100; bus.SrcBE = 32'd7;
                end else if (second < 0) begin
                    second = c; r2 = bus.ResultMDU; bus.StartE = 1'b0;
                end
            end
        end
        bus.StartE = 1'b0;
        compared++;
        if (first !== 33) begin mismatched++; $display("FAIL b2b_first_done: got %0d want 33", first); end
        compared++;
        if (r1 !== 32'hFFFFFFEB) begin mismatched++; $display("FAIL b2b_first_result: got %h want ffffffeb", r1); end
        compared++;
        if (state34 !== IDLE) begin mismatched++; $display("FAIL b2b_c34_state: got %b want %b", state34, IDLE); end
        compared++;
        if (stall34 !== 1'b1) begin mismatched++; $display("FAIL b2b_c34_stall: got %b want 1", stall34); end
        compared++;
        if (second !== 67) begin mismatched++; $display("FAIL b2b_second_done: got %0d want 67", second); end
        compared++;
        if (r2 !== 32'd14) begin mismatched++; $display("FAIL b2b_second_result: got %h want 0000000e", r2); end
        compared++;
        if (ndone !== 2) begin mismatched++; $display("FAIL b2b_done_pulses: got %0d want 2", ndone); end
    endtask
    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
